// File: rtl/collapse_bank_ctrl.sv
// Serialising controller for a bank of collapse cells: round-robin arbitration of
// two readers and one arm port, one operation in flight through IDLE -> ISSUE -> RESP.
module collapse_bank_ctrl #(
    parameter int DATA_W  = 256,
    parameter int BASIS_W = 8,
    parameter int N_SLOTS = 4,
    parameter int SLOT_W  = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        arm_valid,
    input  logic [SLOT_W-1:0]           arm_slot,
    input  logic [DATA_W-1:0]           arm_value,
    input  logic [BASIS_W-1:0]          arm_basis,
    output logic                        arm_ready,
    input  logic [1:0]                  rd_valid,
    input  logic [2*SLOT_W-1:0]         rd_slot,
    input  logic [2*BASIS_W-1:0]        rd_basis,
    output logic [1:0]                  rd_ready,
    output logic                        rsp_valid,
    output logic [1:0]                  rsp_src,
    output logic                        rsp_err,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [N_SLOTS-1:0]          cell_init_en,
    output logic [DATA_W-1:0]           cell_init_value,
    output logic [BASIS_W-1:0]          cell_init_basis,
    output logic [N_SLOTS-1:0]          cell_read_pulse,
    output logic [N_SLOTS*BASIS_W-1:0]  cell_basis_in,
    input  logic [N_SLOTS*DATA_W-1:0]   cell_data_i,
    output logic [2*N_SLOTS-1:0]        slot_state,
    output logic [1:0]                  fsm_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, RESP = 2'd2} state_t;

    localparam logic [1:0] SRC_RD0  = 2'd0;
    localparam logic [1:0] SRC_RD1  = 2'd1;
    localparam logic [1:0] SRC_ARM  = 2'd2;
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_SPENT = 2'd2;

    state_t               state, state_nxt;
    logic [1:0]           rr_ptr;
    logic [1:0]           req_src;
    logic [SLOT_W-1:0]    req_slot;
    logic [BASIS_W-1:0]   req_basis;
    logic [DATA_W-1:0]    req_value;
    logic [1:0]           slot_st [N_SLOTS];

    logic [2:0]           req_vec;
    logic                 grant;
    logic [1:0]           winner;
    logic [2:0]           pos;
    logic [1:0]           cand;
    logic                 is_arm;
    logic                 op_ok;
    logic [DATA_W-1:0]    sel_data;

    // Handshake: a requester holds valid (and its fields) until it sees a one-cycle
    // ready; ready is only ever raised in IDLE, and that cycle is the grant.
    assign req_vec   = {arm_valid, rd_valid};
    assign rd_ready  = {grant && (winner == SRC_RD1), grant && (winner == SRC_RD0)};
    assign arm_ready = grant && (winner == SRC_ARM);
    assign fsm_state = state;

    always_comb begin
        grant  = 1'b0;
        winner = SRC_RD0;
        pos    = '0;
        cand   = '0;
        if (state == IDLE && !rst) begin
            for (int k = 0; k < 3; k++) begin
                pos = {1'b0, rr_ptr} + 3'(k);
                if (pos >= 3'd3) pos = pos - 3'd3;
                cand = pos[1:0];
                if (!grant && req_vec[cand]) begin
                    grant  = 1'b1;
                    winner = cand;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (grant) state_nxt = ISSUE;
            ISSUE:   state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Arms are refused onto a live cell; reads need one.
    always_comb begin
        is_arm          = (req_src == SRC_ARM);
        op_ok           = is_arm ? (slot_st[req_slot] != ST_ARMED) : (slot_st[req_slot] == ST_ARMED);
        sel_data        = cell_data_i[int'(req_slot)*DATA_W +: DATA_W];
        cell_init_en    = '0;
        cell_init_value = '0;
        cell_init_basis = '0;
        cell_read_pulse = '0;
        cell_basis_in   = '0;
        if (state == ISSUE && op_ok) begin
            if (is_arm) begin
                cell_init_en[req_slot] = 1'b1;
                cell_init_value        = req_value;
                cell_init_basis        = req_basis;
            end else begin
                cell_read_pulse[req_slot]                         = 1'b1;
                cell_basis_in[int'(req_slot)*BASIS_W +: BASIS_W] = req_basis;
            end
        end
    end

    always_comb begin
        slot_state = '0;
        for (int i = 0; i < N_SLOTS; i++) slot_state[2*i +: 2] = slot_st[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= SRC_RD0;
            req_src   <= '0;
            req_slot  <= '0;
            req_basis <= '0;
            req_value <= '0;
            rsp_valid <= 1'b0;
            rsp_src   <= '0;
            rsp_err   <= 1'b0;
            rsp_data  <= '0;
            for (int i = 0; i < N_SLOTS; i++) slot_st[i] <= ST_EMPTY;
        end else begin
            if (grant) begin
                rr_ptr  <= (winner == SRC_ARM) ? SRC_RD0 : winner + 2'd1;
                req_src <= winner;
                case (winner)
                    SRC_RD0: begin
                        req_slot  <= rd_slot[SLOT_W-1:0];
                        req_basis <= rd_basis[BASIS_W-1:0];
                        req_value <= '0;
                    end
                    SRC_RD1: begin
                        req_slot  <= rd_slot[2*SLOT_W-1:SLOT_W];
                        req_basis <= rd_basis[2*BASIS_W-1:BASIS_W];
                        req_value <= '0;
                    end
                    default: begin
                        req_slot  <= arm_slot;
                        req_basis <= arm_basis;
                        req_value <= arm_value;
                    end
                endcase
            end
            if (state == ISSUE) begin
                rsp_valid <= 1'b1;
                rsp_src   <= req_src;
                rsp_err   <= !op_ok;
                rsp_data  <= (op_ok && !is_arm) ? sel_data : '0;
                if (op_ok) slot_st[req_slot] <= is_arm ? ST_ARMED : ST_SPENT;
            end
            // Plaintext must not linger past the response cycle.
            if (state == RESP) begin
                rsp_valid <= 1'b0;
                rsp_src   <= '0;
                rsp_err   <= 1'b0;
                rsp_data  <= '0;
                req_value <= '0;
                req_basis <= '0;
            end
        end
    end

endmodule

// File: tb/tb_collapse_bank_ctrl.sv
// Bench for collapse_bank_ctrl: directed scenarios plus randomized traffic, checked each
// cycle against a request-level model of slot lifetimes and round-robin fairness.
module tb_collapse_bank_ctrl;
    localparam int DATA_W  = 256;
    localparam int BASIS_W = 8;
    localparam int N_SLOTS = 4;
    localparam int SLOT_W  = 2;
    localparam int EW      = DATA_W + 3;

    logic                        clk;
    logic                        rst;
    logic                        arm_valid;
    logic [SLOT_W-1:0]           arm_slot;
    logic [DATA_W-1:0]           arm_value;
    logic [BASIS_W-1:0]          arm_basis;
    logic                        arm_ready;
    logic [1:0]                  rd_valid;
    logic [2*SLOT_W-1:0]         rd_slot;
    logic [2*BASIS_W-1:0]        rd_basis;
    logic [1:0]                  rd_ready;
    logic                        rsp_valid;
    logic [1:0]                  rsp_src;
    logic                        rsp_err;
    logic [DATA_W-1:0]           rsp_data;
    logic [N_SLOTS-1:0]          cell_init_en;
    logic [DATA_W-1:0]           cell_init_value;
    logic [BASIS_W-1:0]          cell_init_basis;
    logic [N_SLOTS-1:0]          cell_read_pulse;
    logic [N_SLOTS*BASIS_W-1:0]  cell_basis_in;
    logic [N_SLOTS*DATA_W-1:0]   cell_data_i;
    logic [2*N_SLOTS-1:0]        slot_state;
    logic [1:0]                  fsm_state;

    int checks = 0;
    int errors = 0;

    collapse_bank_ctrl #(.DATA_W(DATA_W), .BASIS_W(BASIS_W), .N_SLOTS(N_SLOTS), .SLOT_W(SLOT_W)) dut (
        .clk(clk), .rst(rst),
        .arm_valid(arm_valid), .arm_slot(arm_slot), .arm_value(arm_value), .arm_basis(arm_basis),
        .arm_ready(arm_ready),
        .rd_valid(rd_valid), .rd_slot(rd_slot), .rd_basis(rd_basis), .rd_ready(rd_ready),
        .rsp_valid(rsp_valid), .rsp_src(rsp_src), .rsp_err(rsp_err), .rsp_data(rsp_data),
        .cell_init_en(cell_init_en), .cell_init_value(cell_init_value), .cell_init_basis(cell_init_basis),
        .cell_read_pulse(cell_read_pulse), .cell_basis_in(cell_basis_in), .cell_data_i(cell_data_i),
        .slot_state(slot_state), .fsm_state(fsm_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- check task ----------------
    task automatic check(input string tag, input logic [DATA_W-1:0] got, input logic [DATA_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- collapse cell bank ----------------
    logic [DATA_W-1:0]  cell_v [N_SLOTS];
    logic [BASIS_W-1:0] cell_b [N_SLOTS];

    always @(posedge clk) begin
        for (int i = 0; i < N_SLOTS; i++) begin
            if (rst) begin
                cell_v[i] <= '0;
                cell_b[i] <= '0;
            end else if (cell_init_en[i]) begin
                cell_v[i] <= cell_init_value;
                cell_b[i] <= cell_init_basis;
            end else if (cell_read_pulse[i]) begin
                cell_v[i] <= '0;
            end
        end
    end

    always_comb begin
        cell_data_i = '0;
        for (int i = 0; i < N_SLOTS; i++)
            if (cell_read_pulse[i] && cell_basis_in[i*BASIS_W +: BASIS_W] == cell_b[i])
                cell_data_i[i*DATA_W +: DATA_W] = cell_v[i];
    end

    // ---------------- reference model + scoreboard ----------------
    logic [2:0]          ready_vec;
    logic [2:0]          valid_vec;
    assign ready_vec = {arm_ready, rd_ready};
    assign valid_vec = {arm_valid, rd_valid};

    logic [EW-1:0]       exp_q[$];
    int                  m_state [N_SLOTS];
    logic [DATA_W-1:0]   m_value [N_SLOTS];
    logic [BASIS_W-1:0]  m_basis [N_SLOTS];
    int                  m_rr;
    int                  age;
    int                  win;
    int                  op_src;
    int                  op_slot;
    logic [BASIS_W-1:0]  op_basis;
    logic [DATA_W-1:0]   op_value;
    logic                op_ok;
    logic [DATA_W-1:0]   exp_data;
    logic [2:0]          exp_ready;
    logic [N_SLOTS-1:0]  exp_ien;
    logic [N_SLOTS-1:0]  exp_rp;
    logic [N_SLOTS*BASIS_W-1:0] exp_bin;
    logic [DATA_W-1:0]   exp_ival;
    logic [BASIS_W-1:0]  exp_ibas;
    logic [2*N_SLOTS-1:0] exp_ss;
    logic [EW-1:0]       e;
    logic                last_rsp_err;
    logic [1:0]          last_rsp_src;
    logic [DATA_W-1:0]   last_rsp_data;

    always @(negedge clk) begin
        if (rst) begin
            check("reset_outputs_zero",
                  |{arm_ready, rd_ready, rsp_valid, rsp_src, rsp_err, rsp_data, cell_init_en,
                    cell_init_value, cell_init_basis, cell_read_pulse, cell_basis_in, slot_state}, 1'b0);
            for (int i = 0; i < N_SLOTS; i++) m_state[i] = 0;
            m_rr = 0;
            age  = -1;
            exp_q.delete();
        end else begin
            exp_ss = '0;
            for (int i = 0; i < N_SLOTS; i++) exp_ss[2*i +: 2] = 2'(m_state[i]);
            check("slot_state", slot_state, exp_ss);

            if (age >= 0) age++;

            exp_ready = '0;
            if (age < 0) begin
                win = -1;
                for (int k = 0; k < 3; k++)
                    if (win < 0 && valid_vec[(m_rr + k) % 3]) win = (m_rr + k) % 3;
                if (win >= 0) begin
                    exp_ready[win] = 1'b1;
                    op_src = win;
                    if (win == 2) begin
                        op_slot  = int'(arm_slot);
                        op_basis = arm_basis;
                        op_value = arm_value;
                        op_ok    = (m_state[op_slot] != 1);
                    end else begin
                        op_slot  = int'(rd_slot[win*SLOT_W +: SLOT_W]);
                        op_basis = rd_basis[win*BASIS_W +: BASIS_W];
                        op_value = '0;
                        op_ok    = (m_state[op_slot] == 1);
                    end
                    exp_data = (op_ok && op_src != 2 && op_basis == m_basis[op_slot]) ? m_value[op_slot] : '0;
                    exp_q.push_back({2'(op_src), !op_ok, exp_data});
                    m_rr = (win + 1) % 3;
                    age  = 0;
                end
            end
            check("ready", ready_vec, exp_ready);

            exp_ien = '0; exp_rp = '0; exp_bin = '0; exp_ival = '0; exp_ibas = '0;
            if (age == 1 && op_ok) begin
                if (op_src == 2) begin
                    exp_ien[op_slot] = 1'b1;
                    exp_ival = op_value;
                    exp_ibas = op_basis;
                    m_state[op_slot] = 1;
                    m_value[op_slot] = op_value;
                    m_basis[op_slot] = op_basis;
                end else begin
                    exp_rp[op_slot] = 1'b1;
                    exp_bin[op_slot*BASIS_W +: BASIS_W] = op_basis;
                    m_state[op_slot] = 2;
                end
            end
            check("cell_init_en", cell_init_en, exp_ien);
            check("cell_read_pulse", cell_read_pulse, exp_rp);
            check("cell_basis_in", cell_basis_in, exp_bin);
            check("cell_init_value", cell_init_value, exp_ival);
            check("cell_init_basis", cell_init_basis, exp_ibas);

            if (age == 2) begin
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
                check("rsp_valid", rsp_valid, 1'b1);
                check("rsp_src", rsp_src, e[EW-1 -: 2]);
                check("rsp_err", rsp_err, e[DATA_W]);
                check("rsp_data", rsp_data, e[DATA_W-1:0]);
                last_rsp_err  = rsp_err;
                last_rsp_src  = rsp_src;
                last_rsp_data = rsp_data;
                age = -1;
            end else begin
                check("rsp_idle", {rsp_valid, rsp_src, rsp_err}, 4'h0);
                check("rsp_data_idle", rsp_data, '0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    function automatic logic [DATA_W-1:0] rand_data();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic set_req(input int r, input logic v, input logic [SLOT_W-1:0] s,
                           input logic [BASIS_W-1:0] b, input logic [DATA_W-1:0] d);
        if (r == 2) begin
            arm_valid = v; arm_slot = s; arm_basis = b; arm_value = d;
        end else begin
            rd_valid[r] = v;
            rd_slot[r*SLOT_W +: SLOT_W]    = s;
            rd_basis[r*BASIS_W +: BASIS_W] = b;
        end
    endtask

    task automatic drive_op(input int r, input logic [SLOT_W-1:0] s,
                            input logic [BASIS_W-1:0] b, input logic [DATA_W-1:0] d);
        logic got;
        int   t;
        @(posedge clk); #1;
        set_req(r, 1'b1, s, b, d);
        got = 1'b0;
        t   = 0;
        while (!got && t < 30) begin
            @(negedge clk);
            got = ready_vec[r];
            t++;
        end
        check("grant_seen", got, 1'b1);
        @(posedge clk); #1;
        set_req(r, 1'b0, '0, '0, '0);
        repeat (2) @(negedge clk);
        #1;
    endtask

    // ---------------- stimulus ----------------
    logic [DATA_W-1:0] pat;
    logic [DATA_W-1:0] val_a;
    logic [2:0]        hold;
    logic [2:0]        seen;
    logic              got;
    int                t;

    initial begin
        rst = 1'b1;
        arm_valid = 1'b0; arm_slot = '0; arm_value = '0; arm_basis = '0;
        rd_valid = '0; rd_slot = '0; rd_basis = '0;
        pat = {8{32'hDEADBEEF}};
        repeat (2) @(negedge clk);
        @(posedge clk); #3 rst = 1'b0;
        #1 check("reset_slot_state", slot_state, '0);

        // arm then correct-basis read
        drive_op(2, 2'd1, 8'h5A, pat);
        check("arm1_err", last_rsp_err, 1'b0);
        check("slot1_armed", slot_state[3:2], 2'b01);
        drive_op(0, 2'd1, 8'h5A, '0);
        check("rd1_src", last_rsp_src, 2'd0);
        check("rd1_err", last_rsp_err, 1'b0);
        check("rd1_data", last_rsp_data, pat);
        check("slot1_spent", slot_state[3:2], 2'b10);

        // second read of a spent slot
        drive_op(1, 2'd1, 8'h5A, '0);
        check("reread_err", last_rsp_err, 1'b1);
        check("reread_data", last_rsp_data, '0);

        // wrong basis, then re-arm
        drive_op(2, 2'd2, 8'h11, rand_data());
        drive_op(1, 2'd2, 8'h12, '0);
        check("wrong_basis_err", last_rsp_err, 1'b0);
        check("wrong_basis_data", last_rsp_data, '0);
        check("slot2_spent", slot_state[5:4], 2'b10);
        drive_op(2, 2'd2, 8'h11, rand_data());
        check("rearm_err", last_rsp_err, 1'b0);
        check("slot2_rearmed", slot_state[5:4], 2'b01);

        // arm on an armed slot leaves contents intact
        val_a = rand_data();
        drive_op(2, 2'd0, 8'h33, val_a);
        drive_op(2, 2'd0, 8'h33, rand_data());
        check("double_arm_err", last_rsp_err, 1'b1);
        drive_op(0, 2'd0, 8'h33, '0);
        check("orig_value_kept", last_rsp_data, val_a);

        // all requesters valid from reset
        @(posedge clk); #1 rst = 1'b1;
        set_req(0, 1'b1, 2'd0, 8'h5A, '0);
        set_req(1, 1'b1, 2'd1, 8'h5A, '0);
        set_req(2, 1'b1, 2'd2, 8'h5A, rand_data());
        @(posedge clk); #3 rst = 1'b0;
        for (int g = 0; g < 6; g++) begin
            got = 1'b0;
            t   = 0;
            while (!got && t < 6) begin
                @(negedge clk);
                if (ready_vec != 3'b000) got = 1'b1;
                else t++;
            end
            check("rr_order", ready_vec, 3'b001 << (g % 3));
            check("rr_gap", t, (g == 0) ? 0 : 2);
        end
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) set_req(r, 1'b0, '0, '0, '0);
        repeat (4) @(negedge clk);

        // reset during ISSUE of a read
        drive_op(2, 2'd3, 8'h44, rand_data());
        @(posedge clk); #1;
        set_req(0, 1'b1, 2'd3, 8'h44, '0);
        got = 1'b0;
        t   = 0;
        while (!got && t < 10) begin
            @(negedge clk);
            got = ready_vec[0];
            t++;
        end
        check("rst_rd_grant", got, 1'b1);
        @(posedge clk); #1;
        set_req(0, 1'b0, '0, '0, '0);
        #2 rst = 1'b1;
        @(negedge clk); #1;
        check("rst_issue_slot_state", slot_state, '0);
        check("rst_issue_read_pulse", cell_read_pulse, '0);
        check("rst_issue_rsp_valid", rsp_valid, 1'b0);
        @(posedge clk); #3 rst = 1'b0;
        repeat (3) @(negedge clk);
        drive_op(0, 2'd3, 8'h44, '0);
        check("rd_after_rst_err", last_rsp_err, 1'b1);

        // randomized traffic
        hold = '0;
        seen = '0;
        repeat (450) begin
            @(posedge clk); #1;
            for (int r = 0; r < 3; r++) begin
                if (hold[r] && seen[r]) begin
                    set_req(r, 1'b0, '0, '0, '0);
                    hold[r] = 1'b0;
                end else if (!hold[r] && $urandom_range(0, 2) == 0) begin
                    set_req(r, 1'b1, 2'($urandom_range(0, N_SLOTS-1)),
                            ($urandom_range(0, 2) == 0) ? 8'h11 : (($urandom_range(0, 1) == 0) ? 8'h5A : 8'hC3),
                            rand_data());
                    hold[r] = 1'b1;
                end
            end
            @(negedge clk);
            seen = ready_vec;
        end
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) set_req(r, 1'b0, '0, '0, '0);
        repeat (5) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
